mul_issue_ctrl: RTL

//  Execute-stage front end for the 64-bit radix-4 Booth multiplier (muler): accepts RV64M mul ops

---
 rtl/mul_pkg.sv | 50 +++++
 rtl/mul_issue_ctrl_if.sv | 28 ++
 rtl/mul_result_fmt.sv | 26 ++
 rtl/mul_issue_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiply issue controller.
// Holds the datapath width, the RV64M op encodings, the controller FSM
// state encoding, the muler signedness codes and small operand helpers.
// Optional feature macro used by the controller: MUL_ZERO_SKIP_EN.
package mul_pkg;

  localparam int XLEN = 64;
  localparam int OP_W = 2;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // muler mul_signed: bit 1 = multiplicand signed, bit 0 = multiplier signed
  localparam logic [1:0] SIGNED_SS = 2'b11;
  localparam logic [1:0] SIGNED_SU = 2'b10;
  localparam logic [1:0] SIGNED_UU = 2'b00;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Word ops always run signed on sign-extended 32-bit operands.
  function automatic logic [1:0] signed_mode(input op_e op, input logic word);
    logic [1:0] mode;
    if (word) begin
      mode = SIGNED_SS;
    end else begin
      case (op)
        OP_MUL, OP_MULH: mode = SIGNED_SS;
        OP_MULHSU:       mode = SIGNED_SU;
        OP_MULHU:        mode = SIGNED_UU;
        default:         mode = SIGNED_SS;
      endcase
    end
    return mode;
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Handshake bundle between the issue controller and the Booth muler.
// master (controller): in_valid, flush, mulw, mul_signed, multiplicand,
//                      multiplier out; out_ready, out_valid, result_hi/lo in.
// slave  (muler)     : the same signals with opposite directions.
interface mul_issue_ctrl_if;
  import mul_pkg::*;

  logic            in_valid;
  logic            flush;
  logic            mulw;
  logic [1:0]      mul_signed;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  modport master (
    output in_valid, flush, mulw, mul_signed, multiplicand, multiplier,
    input  out_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  in_valid, flush, mulw, mul_signed, multiplicand, multiplier,
    output out_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/mul_result_fmt.sv
// Combinational result formatter.
// Ports: op, word (op/width of the op in flight), hi/lo (muler product
// halves) -> data (architectural rd value).
module mul_result_fmt
  import mul_pkg::*;
(
  input  op_e             op,
  input  logic            word,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] data
);

  // Select product half; word ops return the sign-extended low word.
  always_comb begin
    data = lo;
    if (word) begin
      data = sext32(lo[31:0]);
    end else if (op == OP_MUL) begin
      data = lo;
    end else begin
      data = hi;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Execute-stage front end for the radix-4 Booth muler.
// Accepts RV64M multiply ops from EXU, issues them over the muler
// handshake, captures the one-cycle result pulse, and holds the formatted
// rd value until WBU takes it. A flush cancels held or in-flight work; an
// op already inside the muler is drained by discarding its result pulse.
// Ports: clock, reset (async active-low), flush; EXU side in_valid/in_ready/
// in_op/in_word/in_rs1/in_rs2; muler side via mul_issue_ctrl_if.master m;
// WBU side out_valid/out_ready/out_data.
// Optional feature: MUL_ZERO_SKIP_EN -- ops with a zero effective operand
// complete with 0 without being issued to the muler.
module mul_issue_ctrl
  import mul_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  mul_issue_ctrl_if.master m,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
);

  state_e          state_r, state_nxt_s;
  op_e             op_r;
  logic            word_r;
  logic [1:0]      signed_r;
  logic [XLEN-1:0] a_r, b_r;
  logic            out_valid_r;
  logic [XLEN-1:0] out_data_r;
  logic [XLEN-1:0] fmt_data_s;
  logic            accept_s, issue_s, capture_s, skip_s, in_ready_s, zero_s;

`ifdef MUL_ZERO_SKIP_EN
  assign zero_s = (a_r == {XLEN{1'b0}}) || (b_r == {XLEN{1'b0}});
`else
  assign zero_s = 1'b0;
`endif

  mul_result_fmt u_fmt (
    .op   (op_r),
    .word (word_r),
    .hi   (m.result_hi),
    .lo   (m.result_lo),
    .data (fmt_data_s)
  );

  // Next-state and handshake decode; flush outranks every other event.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    capture_s   = 1'b0;
    skip_s      = 1'b0;
    in_ready_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = m.out_ready & ~flush;
        if (in_valid && in_ready_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (zero_s) begin
          skip_s      = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (m.out_ready) begin
          issue_s     = 1'b1;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A pulse arriving with the flush already ends the op: nothing
        // remains in flight, so there is nothing to drain.
        if (flush) begin
          state_nxt_s = m.out_valid ? ST_IDLE : ST_DRAIN;
        end else if (m.out_valid) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (m.out_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture; word ops are reduced to sign-extended low words here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_r     <= OP_MUL;
      word_r   <= 1'b0;
      signed_r <= SIGNED_SS;
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
    end else if (accept_s) begin
      op_r     <= in_word ? OP_MUL : op_e'(in_op);
      word_r   <= in_word;
      signed_r <= signed_mode(op_e'(in_op), in_word);
      a_r      <= in_word ? sext32(in_rs1[31:0]) : in_rs1;
      b_r      <= in_word ? sext32(in_rs2[31:0]) : in_rs2;
    end
  end

  // Result holding register presented to WBU.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {XLEN{1'b0}};
    end else begin
      out_valid_r <= (state_nxt_s == ST_DONE);
      if (capture_s) begin
        out_data_r <= fmt_data_s;
      end else if (skip_s) begin
        out_data_r <= {XLEN{1'b0}};
      end
    end
  end

  assign in_ready       = in_ready_s;
  assign out_valid      = out_valid_r;
  assign out_data       = out_data_r;
  assign m.in_valid     = issue_s;
  assign m.flush        = flush;
  assign m.mulw         = word_r;
  assign m.mul_signed   = signed_r;
  assign m.multiplicand = a_r;
  assign m.multiplier   = b_r;

endmodule
